neuron_backprop_update: RTL

Backward-pass counterpart of the 4-input ReLU neuron. It takes the neuron's forward inputs, current weights and bias, the pre-activation sum and an upstream error. It applies the ReLU derivative, then computes weight and bias gradients one at a time on a single shared multiplier. It writes back SGD-updated 8-bit weights and bias, saturated to the forward datapath's unsigned range, and sits between the training controller and the weight storage.

---
 rtl/neuron_backprop_update.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/neuron_backprop_update.sv
// SGD weight/bias update for the 4-input ReLU neuron. It computes one gradient per cycle on a single shared multiplier.
// Optional GRAD_CLIP_EN clamps each shifted gradient to [-CLIP_MAX, +CLIP_MAX].
module neuron_backprop_update #(
    parameter int LR_SHIFT = 4,
    parameter int CLIP_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [7:0]  x2,
    input  logic [7:0]  x3,
    input  logic [7:0]  w0,
    input  logic [7:0]  w1,
    input  logic [7:0]  w2,
    input  logic [7:0]  w3,
    input  logic [7:0]  bias_in,
    input  logic [17:0] pre_act,
    input  logic [7:0]  err_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  w_out0,
    output logic [7:0]  w_out1,
    output logic [7:0]  w_out2,
    output logic [7:0]  w_out3,
    output logic [7:0]  bias_out
);

`ifdef GRAD_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif
    localparam logic signed [16:0] CLIP_P = 17'(CLIP_MAX);
    localparam logic signed [16:0] CLIP_N = 17'(-CLIP_MAX);

    typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  x_q [4];
    logic [7:0]  x_d [4];
    logic [7:0]  w_q [4];
    logic [7:0]  w_d [4];
    logic [7:0]  w_out_q [4];
    logic [7:0]  w_out_d [4];
    logic [7:0]  bias_q, bias_d, bias_out_q, bias_out_d, err_q, err_d;
    logic        gate_q, gate_d, busy_q, busy_d, done_q, done_d;

    logic signed [7:0]  e;
    logic signed [16:0] g, s, sb;
    logic signed [17:0] n, nb;

    // Arithmetic shift floors toward minus infinity.
    function automatic logic signed [16:0] shift_clip(input logic signed [16:0] v);
        logic signed [16:0] r;
        r = v >>> LR_SHIFT;
        if (CLIP_ON) begin
            if (r > CLIP_P) r = CLIP_P;
            else if (r < CLIP_N) r = CLIP_N;
        end
        return r;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        logic [7:0] r;
        if (v < 18'sd0)        r = 8'd0;
        else if (v > 18'sd255) r = 8'd255;
        else                   r = v[7:0];
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        w_d        = w_q;
        w_out_d    = w_out_q;
        bias_d     = bias_q;
        bias_out_d = bias_out_q;
        err_d      = err_q;
        gate_d     = gate_q;

        e  = gate_q ? $signed(err_q) : 8'sd0;
        g  = 17'(e) * $signed({9'b0, x_q[idx_q]});
        s  = shift_clip(g);
        n  = $signed({10'b0, w_q[idx_q]}) - 18'(s);
        sb = shift_clip(17'(e));
        nb = $signed({10'b0, bias_q}) - 18'(sb);

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d[0] = x0;  x_d[1] = x1;  x_d[2] = x2;  x_d[3] = x3;
                    w_d[0] = w0;  w_d[1] = w1;  w_d[2] = w2;  w_d[3] = w3;
                    bias_d  = bias_in;
                    err_d   = err_in;
                    gate_d  = ~pre_act[17] & (|pre_act);
                    idx_d   = 2'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                w_out_d[idx_q] = sat8(n);
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = BIAS;
            end
            BIAS: begin
                bias_out_d = sat8(nb);
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            bias_q     <= '0;
            bias_out_q <= '0;
            err_q      <= '0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_q[i]     <= '0;
                w_q[i]     <= '0;
                w_out_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            w_q        <= w_d;
            w_out_q    <= w_out_d;
            bias_q     <= bias_d;
            bias_out_q <= bias_out_d;
            err_q      <= err_d;
            gate_q     <= gate_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign w_out0   = w_out_q[0];
    assign w_out1   = w_out_q[1];
    assign w_out2   = w_out_q[2];
    assign w_out3   = w_out_q[3];
    assign bias_out = bias_out_q;

endmodule
